// File: rtl/itoa_stream.sv
// Integer-to-ASCII byte streamer.
// Accepts one SIZE-bit integer per input handshake and emits its text one byte per output
// handshake. Each word selects decimal or hex and signed or unsigned interpretation. Digits
// are zero-padded on the left to MIN_DIGITS. do_last_o marks the final byte of each number.
// Optional feature: define ITOA_EOL_EN to append CR LF after every number. When it is
// enabled, do_last_o rides on the LF byte instead of the final digit.
module itoa_stream #(
  parameter int unsigned SIZE       = 64,
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned HEX_UPPER  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] di_i,
  input  logic            di_signed_i,
  input  logic            di_hex_i,
  input  logic            di_valid_i,
  output logic            di_ready_o,
  output logic [7:0]      do_o,
  output logic            do_valid_o,
  input  logic            do_ready_i,
  output logic            do_last_o
);

  localparam int unsigned   Depth   = SIZE / 3 + 1;
  localparam int unsigned   CntW    = $clog2(Depth + 1);
  localparam logic [SIZE-1:0] Ten   = SIZE'(10);
  localparam logic [7:0]    HexBase = (HEX_UPPER != 0) ? 8'h41 : 8'h61;
`ifdef ITOA_EOL_EN
  localparam logic          DigitLast = 1'b0;
`else
  localparam logic          DigitLast = 1'b1;
`endif

`ifdef ITOA_EOL_EN
  typedef enum logic [2:0] {StIdle, StConv, StSign, StEmit, StEol1, StEol2} state_e;
`else
  typedef enum logic [2:0] {StIdle, StConv, StSign, StEmit} state_e;
`endif

  state_e            state_q;
  logic [SIZE-1:0]   mag_q;
  logic              neg_q;
  logic              hex_q;
  logic [CntW-1:0]   cnt_q;
  logic [7:0]        stack_q [Depth];
  logic [7:0]        do_q;
  logic              do_valid_q;
  logic              do_last_q;

  logic [SIZE-1:0]   mag_next;
  logic [7:0]        digit;
  logic [3:0]        nib;
  logic [CntW-1:0]   cnt_inc;
  logic [CntW-1:0]   top_idx;
  logic [CntW-1:0]   nxt_idx;
  logic              more;

  // Digit extraction for the current magnitude and the stack index arithmetic.
  always_comb begin
    nib      = mag_q[3:0];
    mag_next = '0;
    digit    = 8'h30;
    if (hex_q) begin
      mag_next = mag_q >> 4;
      digit    = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (HexBase + {4'h0, nib} - 8'd10);
    end else begin
      mag_next = mag_q / Ten;
      digit    = 8'h30 + 8'(mag_q % Ten);
    end
    cnt_inc = cnt_q + CntW'(1);
    top_idx = cnt_q - CntW'(1);
    nxt_idx = cnt_q - CntW'(2);
    // Do-while: keep going while digits remain or padding is still owed.
    more    = (mag_next != '0) || ((32'(cnt_q) + 32'd1) < MIN_DIGITS);
  end

  // Conversion and emission FSM with registered byte outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mag_q      <= '0;
      neg_q      <= 1'b0;
      hex_q      <= 1'b0;
      cnt_q      <= '0;
      do_q       <= 8'h00;
      do_valid_q <= 1'b0;
      do_last_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (di_valid_i) begin
            // Negation in SIZE-bit unsigned arithmetic keeps the most-negative value exact.
            if (!di_hex_i && di_signed_i && di_i[SIZE-1]) begin
              mag_q <= '0 - di_i;
              neg_q <= 1'b1;
            end else begin
              mag_q <= di_i;
              neg_q <= 1'b0;
            end
            hex_q   <= di_hex_i;
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          stack_q[cnt_q] <= digit;
          mag_q          <= mag_next;
          cnt_q          <= cnt_inc;
          if (!more) begin
            do_valid_q <= 1'b1;
            if (neg_q) begin
              state_q   <= StSign;
              do_q      <= 8'h2D;
              do_last_q <= 1'b0;
            end else begin
              // Most significant digit is the one being pushed right now.
              state_q   <= StEmit;
              do_q      <= digit;
              do_last_q <= DigitLast && (cnt_q == '0);
            end
          end
        end
        StSign: begin
          if (do_ready_i) begin
            state_q   <= StEmit;
            do_q      <= stack_q[top_idx];
            do_last_q <= DigitLast && (cnt_q == CntW'(1));
          end
        end
        StEmit: begin
          if (do_ready_i) begin
            cnt_q <= top_idx;
            if (cnt_q == CntW'(1)) begin
`ifdef ITOA_EOL_EN
              state_q   <= StEol1;
              do_q      <= 8'h0D;
              do_last_q <= 1'b0;
`else
              state_q    <= StIdle;
              do_valid_q <= 1'b0;
              do_last_q  <= 1'b0;
`endif
            end else begin
              do_q      <= stack_q[nxt_idx];
              do_last_q <= DigitLast && (cnt_q == CntW'(2));
            end
          end
        end
`ifdef ITOA_EOL_EN
        StEol1: begin
          if (do_ready_i) begin
            state_q   <= StEol2;
            do_q      <= 8'h0A;
            do_last_q <= 1'b1;
          end
        end
        StEol2: begin
          if (do_ready_i) begin
            state_q    <= StIdle;
            do_valid_q <= 1'b0;
            do_last_q  <= 1'b0;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

  assign di_ready_o = (state_q == StIdle) && rst_n;
  assign do_o       = do_q;
  assign do_valid_o = do_valid_q;
  assign do_last_o  = do_last_q;

endmodule

// File: tb/tb_itoa_stream.sv
// Bench for itoa_stream: two instances (16-bit/min 1/upper hex, 32-bit/min 4/lower hex),
// randomized and directed numbers checked against a text-formatting reference model.
module tb_itoa_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] di        [2];
  logic        di_signed [2];
  logic        di_hex    [2];
  logic        di_valid  [2];
  logic        di_ready  [2];
  logic [7:0]  dout      [2];
  logic        do_valid  [2];
  logic        do_ready  [2];
  logic        do_last   [2];

  int tests = 0;
  int fails = 0;

  byte unsigned exp_q[$];
  int           exp_digits;

  always #5 clk = ~clk;

  itoa_stream #(.SIZE(16), .MIN_DIGITS(1), .HEX_UPPER(1)) u_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .di_i       (di[0][15:0]),
    .di_signed_i(di_signed[0]),
    .di_hex_i   (di_hex[0]),
    .di_valid_i (di_valid[0]),
    .di_ready_o (di_ready[0]),
    .do_o       (dout[0]),
    .do_valid_o (do_valid[0]),
    .do_ready_i (do_ready[0]),
    .do_last_o  (do_last[0])
  );

  itoa_stream #(.SIZE(32), .MIN_DIGITS(4), .HEX_UPPER(0)) u_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .di_i       (di[1]),
    .di_signed_i(di_signed[1]),
    .di_hex_i   (di_hex[1]),
    .di_valid_i (di_valid[1]),
    .di_ready_o (di_ready[1]),
    .do_o       (dout[1]),
    .do_valid_o (do_valid[1]),
    .do_ready_i (do_ready[1]),
    .do_last_o  (do_last[1])
  );

  // Reference: format the number as text with plain integer arithmetic.
  function automatic void build_exp(input int d, input logic [31:0] v, input bit sgn,
                                    input bit hex);
    int              size;
    int              mind;
    bit              up;
    bit              neg;
    longint unsigned full;
    longint unsigned val;
    longint unsigned base;
    longint unsigned r;
    byte unsigned    digs[$];
    size = (d == 0) ? 16 : 32;
    mind = (d == 0) ? 1 : 4;
    up   = (d == 0);
    full = 64'd1 << size;
    val  = {32'd0, v} % full;
    base = hex ? 64'd16 : 64'd10;
    neg  = !hex && sgn && (val >= full / 2);
    if (neg) val = full - val;
    do begin
      r = val % base;
      if (r < 10) digs.push_front(8'h30 + 8'(r));
      else digs.push_front((up ? 8'h41 : 8'h61) + 8'(r) - 8'd10);
      val = val / base;
    end while (val != 0);
    while (digs.size() < mind) digs.push_front(8'h30);
    exp_digits = digs.size();
    exp_q.delete();
    if (neg) exp_q.push_back(8'h2D);
    foreach (digs[i]) exp_q.push_back(digs[i]);
`ifdef ITOA_EOL_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  function automatic string qstr(input byte unsigned q[$]);
    string s = "";
    foreach (q[i]) s = $sformatf("%s%02h ", s, q[i]);
    return s;
  endfunction

  // Send one number on instance d and check the full output transaction.
  task automatic run_num(input int d, input logic [31:0] v, input bit sgn, input bit hex,
                         input bit bp);
    byte unsigned got[$];
    bit           lasts[$];
    int           c;
    int           cyc;
    bit           stalled;
    bit           stab_bad;
    bit           rdy_bad;
    bit           ok;
    logic [7:0]   held_do;
    logic         held_last;
    string        tag;
    tag = $sformatf("d%0d v=%h s=%0d h=%0d", d, v, sgn, hex);
    build_exp(d, v, sgn, hex);
    c = 0;
    while (di_ready[d] !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    tests++;
    if (di_ready[d] !== 1'b1) begin
      fails++; $display("FAIL input_ready %s: got %b want 1", tag, di_ready[d]);
    end
    di[d] = v; di_signed[d] = sgn; di_hex[d] = hex; di_valid[d] = 1'b1;
    @(negedge clk);
    // While busy, present junk that must be ignored.
    di[d] = $urandom; di_signed[d] = 1'($urandom_range(0, 1));
    di_hex[d] = 1'($urandom_range(0, 1));
    c = 1; rdy_bad = 0;
    while (do_valid[d] !== 1'b1 && c < 200) begin
      if (di_ready[d] !== 1'b0) rdy_bad = 1;
      @(negedge clk); c++;
    end
    tests++;
    if (c - 1 != exp_digits) begin
      fails++; $display("FAIL latency %s: got %0d want %0d", tag, c - 1, exp_digits);
    end
    stalled = 0; stab_bad = 0; cyc = 0; held_do = '0; held_last = 0;
    while (got.size() < exp_q.size() && cyc < 400) begin
      if (di_ready[d] !== 1'b0) rdy_bad = 1;
      if (stalled && (do_valid[d] !== 1'b1 || dout[d] !== held_do || do_last[d] !== held_last))
        stab_bad = 1;
      do_ready[d] = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (do_valid[d] === 1'b1) begin
        if (do_ready[d]) begin
          got.push_back(dout[d]); lasts.push_back(do_last[d]); stalled = 0;
          if (got.size() == exp_q.size()) di_valid[d] = 1'b0;
        end else begin
          stalled = 1; held_do = dout[d]; held_last = do_last[d];
        end
      end else begin
        stalled = 0;
      end
      @(negedge clk); cyc++;
    end
    do_ready[d] = 1'b0; di_valid[d] = 1'b0;
    tests++;
    if (di_ready[d] !== 1'b1 || do_valid[d] !== 1'b0) begin
      fails++;
      $display("FAIL back_to_back %s: got ready=%b valid=%b want ready=1 valid=0", tag,
               di_ready[d], do_valid[d]);
    end
    ok = (got.size() == exp_q.size());
    foreach (got[i]) if (i < exp_q.size() && got[i] !== exp_q[i]) ok = 0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL bytes %s: got %s want %s", tag, qstr(got), qstr(exp_q));
    end
    ok = 1;
    foreach (lasts[i]) if (lasts[i] !== (i == exp_q.size() - 1)) ok = 0;
    tests++;
    if (!ok) begin
      fails++; $display("FAIL last_flag %s: got misplaced want only on byte %0d", tag,
                        exp_q.size() - 1);
    end
    tests++;
    if (rdy_bad) begin
      fails++; $display("FAIL ready_busy %s: got ready=1 while busy want 0", tag);
    end
    if (bp) begin
      tests++;
      if (stab_bad) begin
        fails++; $display("FAIL stall_stable %s: got output change while stalled want hold", tag);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (do_valid[d] !== 1'b0 || do_last[d] !== 1'b0 || dout[d] !== 8'h00 ||
          di_ready[d] !== 1'b0) begin
        fails++;
        $display("FAIL reset_state d%0d: got v=%b l=%b do=%h rdy=%b want 0 0 00 0", d,
                 do_valid[d], do_last[d], dout[d], di_ready[d]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (di_ready[d] !== 1'b1) begin
        fails++; $display("FAIL reset_release d%0d: got ready=%b want 1", d, di_ready[d]);
      end
    end
  endtask

  task automatic test_directed();
    run_num(0, 32'h0000FFF9, 1, 0, 0);
    run_num(0, 32'h00008000, 1, 0, 0);
    run_num(0, 32'h00008000, 0, 0, 0);
    run_num(1, 32'h00BEEF01, 1, 1, 0);
    run_num(0, 32'h0000BEEF, 1, 1, 0);
    run_num(1, 32'h00000000, 0, 0, 0);
    run_num(1, 32'hFFFFFFFB, 1, 0, 0);
    run_num(1, 32'd12345, 0, 0, 0);
    run_num(0, 32'h00000000, 1, 0, 0);
    run_num(0, 32'h0000FFFF, 0, 1, 0);
    run_num(1, 32'hFFFFFFFF, 0, 0, 0);
    run_num(1, 32'h80000000, 1, 0, 0);
    run_num(1, 32'h00000000, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    run_num(0, 32'd907, 0, 0, 1);
    run_num(1, 32'd907, 1, 0, 1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    int c = 0;
    @(negedge clk);
    di[0] = 32'd12345; di_signed[0] = 1'b0; di_hex[0] = 1'b0; di_valid[0] = 1'b1;
    @(negedge clk);
    di_valid[0] = 1'b0; do_ready[0] = 1'b1;
    while (n < 2 && c < 100) begin
      if (do_valid[0] === 1'b1) n++;
      @(negedge clk); c++;
    end
    tests++;
    if (do_valid[0] !== 1'b1 || dout[0] !== 8'h33) begin
      fails++; $display("FAIL mid_third_byte: got v=%b do=%h want 1 33", do_valid[0], dout[0]);
    end
    rst_n = 1'b0; do_ready[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (do_valid[0] !== 1'b0 || do_last[0] !== 1'b0 || dout[0] !== 8'h00 ||
        di_ready[0] !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset: got v=%b l=%b do=%h rdy=%b want 0 0 00 0", do_valid[0],
               do_last[0], dout[0], di_ready[0]);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (di_ready[0] !== 1'b1) begin
      fails++; $display("FAIL mid_release: got ready=%b want 1", di_ready[0]);
    end
    run_num(0, 32'd42, 0, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] v;
      int          d;
      d = int'($urandom_range(0, 1));
      v = $urandom;
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 20);
      if ($urandom_range(0, 7) == 0) v = (d == 0) ? 32'h00008000 : 32'h80000000;
      run_num(d, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) run_num(1, $urandom, 1, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      di[d] = '0; di_signed[d] = 1'b0; di_hex[d] = 1'b0; di_valid[d] = 1'b0;
      do_ready[d] = 1'b0;
    end
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
